// File: rtl/parking_rate_engine.sv
// parking_rate_engine: seconds -> rounded-up minutes x location/band rate -> cents, bit-serial.
// Build option COST_SAT_EN: saturate cost on overflow instead of keeping the low bits.
module parking_rate_engine #(
    parameter int SEC_W  = 12,
    parameter int CST_W  = 14,
    parameter int LOC_W  = 3,
    parameter int RATE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [SEC_W-1:0]  sec_count_i,
    input  logic [LOC_W-1:0]  location_i,
    input  logic [4:0]        hour_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CST_W-1:0]  cost_o,
    output logic              ovf_o,
    output logic              hour_err_o,
    input  logic              rate_we_i,
    input  logic [LOC_W-1:0]  rate_loc_i,
    input  logic [1:0]        rate_band_i,
    input  logic [RATE_W-1:0] rate_wdata_i
);
    localparam int NUM_LOC = 2 ** LOC_W;
    localparam int PW = SEC_W + RATE_W;
    localparam int CW = $clog2(PW + 1);
`ifdef COST_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, DIV60, MUL, DIV100, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SEC_W-1:0]  sec_q, sec_d, min_q, min_d;
    logic [7:0]        r_q, r_d, rs60, rs100;
    logic [PW-1:0]     mc_q, mc_d, p_q, p_d;
    logic [CST_W-1:0]  cost_q, cost_d;
    logic              ovf_q, ovf_d, herr_q, herr_d;
    logic              ge60, ge100, hbad;
    logic [1:0]        band;
    logic [RATE_W-1:0] tbl_q [NUM_LOC][4];

    function automatic logic [RATE_W-1:0] def_rate(input int l, input int b);
        int v;
        v = (l == 0) ? (b == 1 ? 167 : b == 2 ? 189 : 145)
                     : (b == 0 ? 134 : b == 1 ? 156 : b == 2 ? 178 : 156);
        return RATE_W'(v);
    endfunction

    assign band = hour_i < 5'd8 ? 2'd0 : hour_i < 5'd13 ? 2'd1 : hour_i < 5'd18 ? 2'd2 : 2'd3;

    // The accept-cycle read sees the pre-write table contents since writes land on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < NUM_LOC; l++)
                for (int b = 0; b < 4; b++)
                    tbl_q[l][b] <= def_rate(l, b);
        end else if (rate_we_i) begin
            tbl_q[rate_loc_i][rate_band_i] <= rate_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            r_q     <= '0;
            mc_q    <= '0;
            p_q     <= '0;
            cost_q  <= '0;
            ovf_q   <= 1'b0;
            herr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            r_q     <= r_d;
            mc_q    <= mc_d;
            p_q     <= p_d;
            cost_q  <= cost_d;
            ovf_q   <= ovf_d;
            herr_q  <= herr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sec_d   = sec_q;
        min_d   = min_q;
        r_d     = r_q;
        mc_d    = mc_q;
        p_d     = p_q;
        cost_d  = cost_q;
        ovf_d   = ovf_q;
        herr_d  = herr_q;
        hbad    = hour_i >= 5'd24;
        rs60    = {r_q[6:0], sec_q[SEC_W-1]};
        rs100   = {r_q[6:0], p_q[PW-1]};
        ge60    = rs60 >= 8'd60;
        ge100   = rs100 >= 8'd100;
        case (state_q)
            IDLE: if (in_valid_i) begin
                sec_d   = sec_count_i;
                mc_d    = PW'(tbl_q[location_i][band]);
                p_d     = '0;
                r_d     = '0;
                cnt_d   = '0;
                cost_d  = '0;
                ovf_d   = 1'b0;
                herr_d  = hbad;
                state_d = hbad ? DONE : DIV60;
            end
            // Extra cycle at the end rounds the minute count up.
            DIV60: if (cnt_q == CW'(SEC_W)) begin
                min_d   = sec_q + SEC_W'(r_q != 8'd0);
                cnt_d   = '0;
                state_d = MUL;
            end else begin
                r_d   = ge60 ? rs60 - 8'd60 : rs60;
                sec_d = {sec_q[SEC_W-2:0], ge60};
                cnt_d = cnt_q + 1'b1;
            end
            // The +50 for half-up rounding is folded into the last partial-product add.
            MUL: begin
                p_d   = p_q + (min_q[0] ? mc_q : '0) + (cnt_q == CW'(SEC_W - 1) ? PW'(50) : '0);
                mc_d  = mc_q << 1;
                min_d = min_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(SEC_W - 1)) begin
                    cnt_d   = '0;
                    r_d     = '0;
                    state_d = DIV100;
                end
            end
            DIV100: begin
                r_d   = ge100 ? rs100 - 8'd100 : rs100;
                p_d   = {p_q[PW-2:0], ge100};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(PW - 1)) begin
                    ovf_d   = (p_d >> CST_W) != '0;
                    cost_d  = (ovf_d && SAT) ? '1 : p_d[CST_W-1:0];
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready_o  = rst_n && state_q == IDLE;
    assign out_valid_o = state_q == DONE;
    assign cost_o      = cost_q;
    assign ovf_o       = ovf_q;
    assign hour_err_o  = herr_q;
endmodule

// File: tb/tb_parking_rate_engine.sv
// tb_parking_rate_engine: vector table plus scoreboard for parking_rate_engine, with
// hand-written hold, accept-cycle write, mid-run reset and narrow-cost overflow sequences.
module tb_parking_rate_engine;
    localparam int SEC_W = 12, CST_W = 14, LOC_W = 3, RATE_W = 8;
    localparam int LAT = 3 * SEC_W + RATE_W + 1;

    typedef struct { int sec; int loc; int hour; int cost; int ovf; int herr; } vec_t;
    typedef struct { int cost; int ovf; int herr; int acc; } exp_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_valid_s = 1'b0, out_ready = 1'b1;
    logic [SEC_W-1:0] sec = '0;
    logic [LOC_W-1:0] loc = '0, rate_loc = '0;
    logic [4:0] hour = '0;
    logic [1:0] rate_band = '0;
    logic [RATE_W-1:0] rate_wdata = '0;
    logic rate_we = 1'b0;
    logic in_ready, out_valid, ovf, herr, in_ready_s, out_valid_s, ovf_s, herr_s;
    logic [CST_W-1:0] cost;
    logic [6:0] cost_s;

    int cyc = 0, errors = 0, checks = 0;
    bit seen = 0;
    exp_t sb[$];
    vec_t vecs[12];

    parking_rate_engine #(.SEC_W(SEC_W), .CST_W(CST_W), .LOC_W(LOC_W), .RATE_W(RATE_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .sec_count_i(sec), .location_i(loc), .hour_i(hour), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .cost_o(cost), .ovf_o(ovf), .hour_err_o(herr),
        .rate_we_i(rate_we), .rate_loc_i(rate_loc), .rate_band_i(rate_band), .rate_wdata_i(rate_wdata));

    parking_rate_engine #(.SEC_W(SEC_W), .CST_W(7), .LOC_W(LOC_W), .RATE_W(RATE_W)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_s), .in_ready_o(in_ready_s),
        .sec_count_i(sec), .location_i(loc), .hour_i(hour), .out_valid_o(out_valid_s),
        .out_ready_i(out_ready), .cost_o(cost_s), .ovf_o(ovf_s), .hour_err_o(herr_s),
        .rate_we_i(rate_we), .rate_loc_i(rate_loc), .rate_band_i(rate_band), .rate_wdata_i(rate_wdata));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: latency on the first valid cycle, values on the handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (!seen) begin
                seen = 1;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got cost %0d with empty scoreboard", cost);
                end else chk("latency", cyc - sb[0].acc, sb[0].herr != 0 ? 0 : LAT);
            end
            if (out_ready) begin
                seen = 0;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("cost", cost, e.cost);
                    chk("ovf", ovf, e.ovf);
                    chk("hour_err", herr, e.herr);
                end
            end
        end
    end

    task automatic send(input vec_t v, input bit wr);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_send", in_ready, 1);
        if (!in_ready) return;
        in_valid = 1'b1;
        sec = SEC_W'(v.sec);
        loc = LOC_W'(v.loc);
        hour = 5'(v.hour);
        rate_we = wr;
        rate_loc = 3'd2;
        rate_band = 2'd3;
        rate_wdata = 8'd200;
        sb.push_back('{v.cost, v.ovf, v.herr, cyc + 1});
        @(posedge clk); #1;
        in_valid = 1'b0;
        rate_we = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        vecs = '{
            '{61,   0, 9,  3,   0, 0},
            '{600,  1, 14, 18,  0, 0},
            '{0,    3, 3,  0,   0, 0},
            '{1500, 1, 0,  34,  0, 0},
            '{4095, 0, 20, 100, 0, 0},
            '{59,   5, 12, 2,   0, 0},
            '{3600, 7, 23, 94,  0, 0},
            '{60,   0, 0,  1,   0, 0},
            '{100,  4, 24, 0,   0, 1},
            '{5,    6, 31, 0,   0, 1},
            '{121,  3, 17, 5,   0, 0},
            '{4095, 7, 13, 123, 0, 0}
        };
        repeat (3) @(posedge clk);
        #1 chk("in_ready_in_reset", in_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cost", cost, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_hour_err", herr, 0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            send(vecs[i], 1'b0);
            wait_idle();
        end

        // Held hour-error result while busy requests are ignored.
        out_ready = 1'b0;
        send('{100, 0, 24, 0, 0, 1}, 1'b0);
        repeat (10) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_cost", cost, 0);
            chk("hold_hour_err", herr, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_in_ready", in_ready, 1);
        chk("post_hs_out_valid", out_valid, 0);
        wait_idle();

        // Write on the accept cycle: old rate 156 applies now, 200 applies next.
        send('{120, 2, 20, 3, 0, 0}, 1'b1);
        wait_idle();
        send('{120, 2, 20, 4, 0, 0}, 1'b0);
        wait_idle();

        // Reset mid-computation discards the run and restores the table.
        send('{120, 2, 20, 4, 0, 0}, 1'b0);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        seen = 0;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);
        chk("rel_cost", cost, 0);
        send('{120, 2, 20, 3, 0, 0}, 1'b0);
        wait_idle();

        // Narrow cost width: 69 min x 189 -> 130 does not fit 7 bits.
        chk("small_in_ready", in_ready_s, 1);
        in_valid_s = 1'b1;
        sec = 12'd4095;
        loc = 3'd0;
        hour = 5'd15;
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        n = 0;
        while (!out_valid_s && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("small_latency", n, LAT);
        chk("small_ovf", ovf_s, 1);
        chk("small_hour_err", herr_s, 0);
`ifdef COST_SAT_EN
        chk("small_cost", cost_s, 127);
`else
        chk("small_cost", cost_s, 2);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("small_in_ready_after", in_ready_s, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
